intctl: RTL and testbench

Memory-mapped interrupt controller sitting downstream of the computer's `irqs` vector and upstream of the CPU interrupt input. It latches or tracks up to 32 sources, applies per-source enable and edge/level mode, and selects the lowest-numbered active source. It presents that source to the CPU with a request/acknowledge handshake and holds it in service until software writes end-of-interrupt. Registers sit on the shared memory bus as one more `cs_io` slot, alongside the timer and GPIO blocks.

---
 rtl/intctl_pkg.sv | 22 ++
 rtl/intctl_prio.sv | 22 ++
 rtl/intctl.sv | 194 +++++++++++++++++++
 tb/tb_intctl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/intctl_pkg.sv
// Shared definitions for the intctl interrupt controller: register offsets,
// FSM state encoding and the width of a source index.
package intctl_pkg;

   localparam int IRQ_ID_W = 5;

   localparam logic [2:0] INTCTL_PEND   = 3'd0;
   localparam logic [2:0] INTCTL_ENABLE = 3'd1;
   localparam logic [2:0] INTCTL_MODE   = 3'd2;
   localparam logic [2:0] INTCTL_ACTIVE = 3'd3;
   localparam logic [2:0] INTCTL_SET    = 3'd4;
   localparam logic [2:0] INTCTL_EOI    = 3'd5;
   localparam logic [2:0] INTCTL_MASKED = 3'd6;
   localparam logic [2:0] INTCTL_CTRL   = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_SVC  = 2'd2
   } intctl_state_e;

endpackage

// File: rtl/intctl_prio.sv
// Combinational lowest-index-first priority encoder: NIRQ request bits in,
// "anything set" flag and the index of the lowest set bit out.
module intctl_prio
   import intctl_pkg::*;
#(
   parameter int NIRQ = 32
) (
   input  logic [NIRQ-1:0]     req,
   output logic                any,
   output logic [IRQ_ID_W-1:0] id
);

   // Scanning downward lets the lowest set bit overwrite any higher one.
   always_comb begin
      any = |req;
      id  = {IRQ_ID_W{1'b0}};
      for (int i = NIRQ - 1; i >= 0; i--) begin
         id = req[i] ? IRQ_ID_W'(i) : id;
      end
   end

endmodule

// File: rtl/intctl.sv
// Memory-mapped interrupt controller with edge/level sources, lowest-index
// priority and a req/ack/EOI service handshake. Define INTCTL_SYNC_EN to add a
// 2-flop synchroniser on every irq_in bit.
module intctl
   import intctl_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int NIRQ  = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cs,
   input  logic                wen,
   input  logic [2:0]          addr,
   input  logic [WIDTH-1:0]    din,
   output logic [WIDTH-1:0]    dout,
   input  logic [NIRQ-1:0]     irq_in,
   output logic                irq_req,
   output logic [IRQ_ID_W-1:0] irq_id,
   input  logic                irq_ack
);

   logic [NIRQ-1:0]     src;
   logic [NIRQ-1:0]     prev;
   logic [NIRQ-1:0]     pend_edge;
   logic [NIRQ-1:0]     pend;
   logic [NIRQ-1:0]     enable;
   logic [NIRQ-1:0]     mode;
   logic [NIRQ-1:0]     masked;
   logic [NIRQ-1:0]     w1c_bits;
   logic [NIRQ-1:0]     set_bits;
   logic [NIRQ-1:0]     edge_bits;
   logic [NIRQ-1:0]     ack_clr;
   logic                gie;
   logic                active_valid;
   logic [IRQ_ID_W-1:0] active_id;
   logic                cand_any;
   logic [IRQ_ID_W-1:0] cand_id;
   logic                any;
   logic                wr;
   logic                wr_eoi;
   logic                ack_fire;
   logic                eoi_fire;
   intctl_state_e       state;
   intctl_state_e       state_next;
   logic [IRQ_ID_W-1:0] id_next;

`ifdef INTCTL_SYNC_EN
   logic [NIRQ-1:0] sync1;
   logic [NIRQ-1:0] sync2;

   // Two-stage synchroniser for sources from a foreign clock domain.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= {NIRQ{1'b0}};
         sync2 <= {NIRQ{1'b0}};
      end else begin
         sync1 <= irq_in;
         sync2 <= sync1;
      end
   end

   assign src = sync2;
`else
   assign src = irq_in;
`endif

   assign wr        = cs & wen;
   assign wr_eoi    = wr & (addr == INTCTL_EOI);
   assign w1c_bits  = (wr && addr == INTCTL_PEND) ? din[NIRQ-1:0] : {NIRQ{1'b0}};
   assign set_bits  = (wr && addr == INTCTL_SET)  ? din[NIRQ-1:0] : {NIRQ{1'b0}};
   assign edge_bits = src & ~prev;

   // Level-mode bits follow the line directly; only edge-mode bits are latched.
   assign pend   = (pend_edge & mode) | (src & ~mode);
   assign masked = pend & enable;
   assign any    = cand_any & gie;

   intctl_prio #(.NIRQ(NIRQ)) u_prio (
      .req (masked),
      .any (cand_any),
      .id  (cand_id)
   );

   always_comb begin
      for (int i = 0; i < NIRQ; i++) begin
         ack_clr[i] = ack_fire & (irq_id == IRQ_ID_W'(i));
      end
   end

   // Request FSM; an ack in the same cycle as a withdrawal still wins.
   always_comb begin
      state_next = state;
      id_next    = irq_id;
      ack_fire   = 1'b0;
      eoi_fire   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (any) begin
               state_next = ST_REQ;
               id_next    = cand_id;
            end else begin
               state_next = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (irq_ack) begin
               state_next = ST_SVC;
               ack_fire   = 1'b1;
            end else if (!masked[irq_id] || !gie) begin
               state_next = ST_IDLE;
            end else begin
               state_next = ST_REQ;
            end
         end
         ST_SVC: begin
            if (wr_eoi) begin
               state_next = ST_IDLE;
               eoi_fire   = 1'b1;
            end else begin
               state_next = ST_SVC;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Configuration, pending latch and edge history. New edges beat clears.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev      <= {NIRQ{1'b0}};
         pend_edge <= {NIRQ{1'b0}};
         enable    <= {NIRQ{1'b0}};
         mode      <= {NIRQ{1'b0}};
         gie       <= 1'b0;
      end else begin
         prev      <= src;
         pend_edge <= mode & ((pend_edge & ~w1c_bits & ~ack_clr) | edge_bits | set_bits);
         if (wr && addr == INTCTL_ENABLE) begin
            enable <= din[NIRQ-1:0];
         end
         if (wr && addr == INTCTL_MODE) begin
            mode <= din[NIRQ-1:0];
         end
         if (wr && addr == INTCTL_CTRL) begin
            gie <= din[0];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         irq_req      <= 1'b0;
         irq_id       <= {IRQ_ID_W{1'b0}};
         active_valid <= 1'b0;
         active_id    <= {IRQ_ID_W{1'b0}};
      end else begin
         state   <= state_next;
         irq_req <= (state_next == ST_REQ);
         irq_id  <= id_next;
         if (ack_fire) begin
            active_valid <= 1'b1;
            active_id    <= irq_id;
         end else if (eoi_fire) begin
            active_valid <= 1'b0;
            active_id    <= {IRQ_ID_W{1'b0}};
         end
      end
   end

   always_comb begin
      dout = {WIDTH{1'b0}};
      if (cs) begin
         case (addr)
            INTCTL_PEND:   dout[NIRQ-1:0] = pend;
            INTCTL_ENABLE: dout[NIRQ-1:0] = enable;
            INTCTL_MODE:   dout[NIRQ-1:0] = mode;
            INTCTL_ACTIVE: begin
               dout[31]           = active_valid;
               dout[IRQ_ID_W-1:0] = active_id;
            end
            INTCTL_MASKED: dout[NIRQ-1:0] = masked;
            INTCTL_CTRL:   dout[0] = gie;
            default:       dout = {WIDTH{1'b0}};
         endcase
      end else begin
         dout = {WIDTH{1'b0}};
      end
   end

endmodule

// File: tb/tb_intctl.sv
// Directed bench for intctl: a per-cycle reference model checked on every
// falling edge, plus hand-computed expectations for the documented scenarios.
module tb_intctl;

`ifdef INTCTL_SYNC_EN
   localparam int SYNC = 2;
`else
   localparam int SYNC = 0;
`endif
   localparam int LAT_E = 2 + SYNC;
   localparam int LAT_L = 1 + SYNC;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cs = 1'b0;
   logic        wen = 1'b0;
   logic [2:0]  addr = 3'd0;
   logic [31:0] din = 32'd0;
   logic [31:0] dout;
   logic [31:0] irq_in = 32'd0;
   logic        irq_req;
   logic [4:0]  irq_id;
   logic        irq_ack = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   intctl #(.WIDTH(32), .NIRQ(32)) dut (
      .clk     (clk),
      .reset   (reset),
      .cs      (cs),
      .wen     (wen),
      .addr    (addr),
      .din     (din),
      .dout    (dout),
      .irq_in  (irq_in),
      .irq_req (irq_req),
      .irq_id  (irq_id),
      .irq_ack (irq_ack)
   );

   always #5 clk = ~clk;

   // Reference model state: state 0 idle, 1 requesting, 2 in service.
   logic [31:0] m_lat = 32'd0, m_en = 32'd0, m_mode = 32'd0;
   logic [31:0] m_prev = 32'd0, m_s1 = 32'd0, m_s2 = 32'd0;
   logic        m_gie = 1'b0, m_av = 1'b0;
   logic [4:0]  m_id = 5'd0, m_aid = 5'd0;
   int          m_state = 0;

   function automatic logic [31:0] line_now();
`ifdef INTCTL_SYNC_EN
      return m_s2;
`else
      return irq_in;
`endif
   endfunction

   function automatic logic [31:0] pend_view();
      return (m_lat & m_mode) | (line_now() & ~m_mode);
   endfunction

   function automatic logic [31:0] masked_now();
      return pend_view() & m_en;
   endfunction

   function automatic int lowest(logic [31:0] v);
      for (int i = 0; i < 32; i++) if (v[i]) return i;
      return -1;
   endfunction

   function automatic logic [31:0] next_lat();
      logic [31:0] ln;
      logic [31:0] r;
      logic        clr;
      ln = line_now();
      r  = 32'd0;
      for (int i = 0; i < 32; i++) begin
         if (m_mode[i]) begin
            clr  = (cs && wen && addr == 3'd0 && din[i]) ||
                   (m_state == 1 && irq_ack && m_id == 5'(i));
            r[i] = (ln[i] & ~m_prev[i]) | (cs && wen && addr == 3'd4 && din[i]) |
                   (m_lat[i] & ~clr);
         end
      end
      return r;
   endfunction

   function automatic logic [31:0] exp_dout();
      if (!cs) return 32'd0;
      case (addr)
         3'd0: return pend_view();
         3'd1: return m_en;
         3'd2: return m_mode;
         3'd3: return {m_av, 26'd0, m_aid};
         3'd6: return masked_now();
         3'd7: return {31'd0, m_gie};
         default: return 32'd0;
      endcase
   endfunction

   initial forever begin : model
      logic [31:0] mk;
      int          c;
      @(posedge clk or posedge reset);
      if (reset) begin
         m_lat <= 32'd0; m_en <= 32'd0; m_mode <= 32'd0; m_gie <= 1'b0;
         m_prev <= 32'd0; m_s1 <= 32'd0; m_s2 <= 32'd0;
         m_state <= 0; m_id <= 5'd0; m_av <= 1'b0; m_aid <= 5'd0;
      end else begin
         mk = masked_now();
         c  = lowest(mk);
         m_lat  <= next_lat();
         m_prev <= line_now();
         m_s1   <= irq_in;
         m_s2   <= m_s1;
         if (cs && wen) begin
            case (addr)
               3'd1: m_en <= din;
               3'd2: m_mode <= din;
               3'd7: m_gie <= din[0];
               default: ;
            endcase
         end
         case (m_state)
            0: if (m_gie && c >= 0) begin m_state <= 1; m_id <= 5'(c); end
            1: if (irq_ack) begin
                  m_state <= 2; m_av <= 1'b1; m_aid <= m_id;
               end else if (!mk[m_id] || !m_gie) begin
                  m_state <= 0;
               end
            2: if (cs && wen && addr == 3'd5) begin
                  m_state <= 0; m_av <= 1'b0; m_aid <= 5'd0;
               end
            default: m_state <= 0;
         endcase
      end
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask

   initial forever begin
      @(negedge clk);
      chk("irq_req", {31'd0, irq_req}, {31'd0, m_state == 1});
      chk("irq_id", {27'd0, irq_id}, {27'd0, m_id});
      if (cs) chk("dout", dout, exp_dout());
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic tickn(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      cs = 1'b1; wen = 1'b1; addr = a; din = d;
      tick();
      cs = 1'b0; wen = 1'b0; din = 32'd0;
   endtask

   task automatic rd_chk(input string nm, input logic [2:0] a, input logic [31:0] exp);
      cs = 1'b1; wen = 1'b0; addr = a;
      #1;
      chk(nm, dout, exp);
      tick();
      cs = 1'b0;
   endtask

   task automatic ack();
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
   endtask

   task automatic req_chk(input string nm, input logic r, input logic [4:0] id);
      chk({nm, "_req"}, {31'd0, irq_req}, {31'd0, r});
      if (r) chk({nm, "_id"}, {27'd0, irq_id}, {27'd0, id});
   endtask

   initial begin
      tickn(3);
      reset = 1'b0;
      req_chk("rst", 1'b0, 5'd0);
      chk("rst_id", {27'd0, irq_id}, 32'd0);
      for (int a = 0; a < 8; a++) rd_chk("rst_reg", 3'(a), 32'd0);

      // Single edge source, full req/ack/EOI round trip.
      wr(3'd1, 32'h2); wr(3'd2, 32'h2); wr(3'd7, 32'h1);
      irq_in = 32'h2; tick(); irq_in = 32'h0;
      tickn(LAT_E - 2);
      req_chk("t1_early", 1'b0, 5'd0);
      tick();
      req_chk("t1", 1'b1, 5'd1);
      ack();
      req_chk("t1_ack", 1'b0, 5'd0);
      rd_chk("t1_pend", 3'd0, 32'h0);
      chk("t1_model_act", {m_av, 26'd0, m_aid}, 32'h8000_0001);
      rd_chk("t1_active", 3'd3, 32'h8000_0001);
      wr(3'd5, 32'h0);
      rd_chk("t1_eoi", 3'd3, 32'h0);

      // Two simultaneous edges: lowest index first.
      wr(3'd1, 32'hFFFF_FFFF); wr(3'd2, 32'hFFFF_FFFF);
      irq_in = 32'h28; tick(); irq_in = 32'h0;
      tickn(LAT_E - 1);
      req_chk("t2_first", 1'b1, 5'd3);
      ack();
      rd_chk("t2_pend", 3'd0, 32'h20);
      wr(3'd5, 32'h0);
      req_chk("t2_eoi", 1'b0, 5'd0);
      tick();
      req_chk("t2_second", 1'b1, 5'd5);
      ack();
      wr(3'd5, 32'h0);

      // Level source re-requests after EOI and withdraws when dropped.
      wr(3'd1, 32'h1); wr(3'd2, 32'h0);
      irq_in = 32'h1;
      tickn(LAT_L);
      req_chk("t3", 1'b1, 5'd0);
      ack();
      wr(3'd5, 32'h0);
      tick();
      req_chk("t3_again", 1'b1, 5'd0);
      irq_in = 32'h0;
      tickn(LAT_L);
      req_chk("t3_drop", 1'b0, 5'd0);

      // Software SET, then W1C while requesting withdraws the request.
      wr(3'd1, 32'h10); wr(3'd2, 32'h10);
      wr(3'd4, 32'h10);
      tick();
      req_chk("t4", 1'b1, 5'd4);
      wr(3'd0, 32'h10);
      tick();
      req_chk("t4_w1c", 1'b0, 5'd0);
      rd_chk("t4_pend", 3'd0, 32'h0);

      // Edge and W1C on the same bit in one cycle, then reset in service.
      wr(3'd1, 32'h4); wr(3'd2, 32'h4);
      irq_in = 32'h4; cs = 1'b1; wen = 1'b1; addr = 3'd0; din = 32'h4;
      tick();
      irq_in = 32'h0; cs = 1'b0; wen = 1'b0; din = 32'h0;
      tickn(LAT_E - 2);
      rd_chk("t5_pend", 3'd0, 32'h4);
      req_chk("t5", 1'b1, 5'd2);
      ack();
      rd_chk("t5_active", 3'd3, 32'h8000_0002);
      reset = 1'b1;
      #1;
      chk("t5_rst_req", {31'd0, irq_req}, 32'd0);
      chk("t5_rst_id", {27'd0, irq_id}, 32'd0);
      cs = 1'b1; addr = 3'd6;
      #1;
      chk("t5_rst_masked", dout, 32'd0);
      addr = 3'd3;
      #1;
      chk("t5_rst_active", dout, 32'd0);
      tick();
      reset = 1'b0; cs = 1'b0;
      tickn(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
